video_stream_capture: RTL and testbench

VIDEO_STREAM_CAPTURE -- requirements
Module: video_stream_capture

---
 rtl/video_stream_capture_if.sv | 30 +++
 rtl/video_stream_capture.sv | 173 +++++++++++++++++
 tb/tb_video_stream_capture.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/video_stream_capture_if.sv
`default_nettype none
// ============================================================================
// Module      : video_stream_capture_if
// Description : Avalon-ST pixel stream bundle (30-bit RGB beat, SOP/EOP, valid/ready).
// Revision    : 1.0 - initial release
// ============================================================================
interface video_stream_capture_if;
    logic [29:0] data;
    logic        startofpacket;
    logic        endofpacket;
    logic        valid;
    logic        ready;

    modport master (
        output data,
        output startofpacket,
        output endofpacket,
        output valid,
        input  ready
    );

    modport slave (
        input  data,
        input  startofpacket,
        input  endofpacket,
        input  valid,
        output ready
    );
endinterface
`default_nettype wire

// File: rtl/video_stream_capture.sv
`default_nettype none
// ============================================================================
// Module      : video_stream_capture
// Description : Captures one framed Avalon-ST video packet into a 4:4:4 BRAM buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module video_stream_capture #(
    parameter int NumPixels     = 144,
    parameter int NumColourBits = 12
) (
    input  wire logic                     clk,
    input  wire logic                     reset,
    video_stream_capture_if.slave         st,
    input  wire logic                     arm,
    input  wire logic                     continuous,
    output logic                          busy,
    output logic                          frame_done,
    output logic                          frame_error,
    output logic [15:0]                   frame_count,
    input  wire logic [18:0]              rd_addr,
    output logic [NumColourBits-1:0]      rd_data
);

    localparam int          AW       = (NumPixels > 2) ? $clog2(NumPixels) : 1;
    localparam logic [18:0] LAST_IDX = 19'(NumPixels - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SYNC    = 2'd1,
        CAPTURE = 2'd2
    } state_e;

    state_e                    state_q;
    logic [18:0]               idx_q;
    logic                      ready_q;
    logic                      done_q;
    logic                      error_q;
    logic [15:0]               count_q;
    logic [NumColourBits-1:0]  rd_data_q;

    logic                      beat;
    logic                      sop;
    logic                      eop;
    logic                      mem_we;
    logic [AW-1:0]             mem_waddr;
    logic [NumColourBits-1:0]  pixel;

    logic [NumColourBits-1:0]  mem [NumPixels];

    assign beat  = st.valid & ready_q;
    assign sop   = st.startofpacket;
    assign eop   = st.endofpacket;
    assign pixel = NumColourBits'({st.data[29:26], st.data[19:16], st.data[9:6]});

    // Pad bits of each colour channel are deliberately dropped.
    logic unused_data_pad;
    assign unused_data_pad = ^{st.data[25:20], st.data[15:10], st.data[5:0]};

    // A SOP always restarts at address 0; the last pixel is only written when EOP confirms it.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = idx_q[AW-1:0];
        if (beat) begin
            case (state_q)
                SYNC: begin
                    if (sop) begin
                        mem_we    = 1'b1;
                        mem_waddr = '0;
                    end
                end
                CAPTURE: begin
                    if (sop) begin
                        mem_we    = 1'b1;
                        mem_waddr = '0;
                    end else if ((idx_q != LAST_IDX) || eop) begin
                        mem_we = 1'b1;
                    end
                end
                default: mem_we = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            count_q <= '0;
        end else begin
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (arm) begin
                        state_q <= SYNC;
                    end
                end
                SYNC: begin
                    // SOP+EOP together is a one-pixel frame: stored, then rejected.
                    if (beat && sop) begin
                        if (eop) begin
                            error_q <= 1'b1;
                        end else begin
                            idx_q   <= 19'd1;
                            state_q <= CAPTURE;
                        end
                    end
                end
                CAPTURE: begin
                    if (beat) begin
                        if (sop) begin
                            error_q <= 1'b1;
                            if (eop) begin
                                idx_q   <= '0;
                                state_q <= SYNC;
                            end else begin
                                idx_q <= 19'd1;
                            end
                        end else if (idx_q == LAST_IDX) begin
                            idx_q <= '0;
                            if (eop) begin
                                done_q  <= 1'b1;
                                count_q <= count_q + 16'd1;
                                state_q <= continuous ? SYNC : IDLE;
                            end else begin
                                error_q <= 1'b1;
                                state_q <= SYNC;
                            end
                        end else if (eop) begin
                            error_q <= 1'b1;
                            idx_q   <= '0;
                            state_q <= SYNC;
                        end else begin
                            idx_q <= idx_q + 19'd1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    idx_q   <= '0;
                end
            endcase
        end
    end

    // Read-before-write: a same-address read returns the previous contents.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= pixel;
        end
        rd_data_q <= mem[rd_addr[AW-1:0]];
    end

    generate
        if (AW < 19) begin : g_rd_addr_upper
            logic unused_rd_addr_upper;
            assign unused_rd_addr_upper = |rd_addr[18:AW];
        end
    endgenerate

    assign st.ready    = ready_q;
    assign busy        = (state_q != IDLE);
    assign frame_done  = done_q;
    assign frame_error = error_q;
    assign frame_count = count_q;
    assign rd_data     = rd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_video_stream_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_video_stream_capture
// Description : Randomised self-checking bench for video_stream_capture with a frame-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_video_stream_capture;

    localparam int N = 144;

    logic        clk = 1'b0;
    logic        reset;
    logic        arm;
    logic        continuous;
    logic        busy;
    logic        frame_done;
    logic        frame_error;
    logic [15:0] frame_count;
    logic [18:0] rd_addr;
    logic [11:0] rd_data;

    always #5 clk = ~clk;

    video_stream_capture_if st_if();

    video_stream_capture #(
        .NumPixels     (N),
        .NumColourBits (12)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .st          (st_if),
        .arm         (arm),
        .continuous  (continuous),
        .busy        (busy),
        .frame_done  (frame_done),
        .frame_error (frame_error),
        .frame_count (frame_count),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference model: "armed" means waiting for or collecting a frame; pos<0 means hunting SOP.
    bit          m_armed;
    int          m_pos;
    bit          m_ready;
    int          m_count;
    bit          e_done;
    bit          e_err;
    logic [11:0] m_mem   [N];
    bit          m_known [N];

    bit          d_valid, d_sop, d_eop;
    logic [11:0] d_pix;

    function automatic logic [29:0] enc(input logic [11:0] p);
        logic [5:0] a, b, c;
        a = 6'($urandom);
        b = 6'($urandom);
        c = 6'($urandom);
        return {p[11:8], a, p[7:4], b, p[3:0], c};
    endfunction

    task automatic model_cycle();
        bit took;
        e_done = 1'b0;
        e_err  = 1'b0;
        if (reset) begin
            m_armed = 1'b0;
            m_pos   = -1;
            m_ready = 1'b0;
            m_count = 0;
            return;
        end
        took    = d_valid && m_ready;
        m_ready = 1'b1;
        if (!m_armed) begin
            if (arm) m_armed = 1'b1;
        end else if (took) begin
            if (d_sop) begin
                m_mem[0]   = d_pix;
                m_known[0] = 1'b1;
                if (m_pos >= 0 || d_eop) e_err = 1'b1;
                m_pos = d_eop ? -1 : 1;
            end else if (m_pos >= 0) begin
                if (m_pos == N - 1 && !d_eop) begin
                    e_err = 1'b1;
                    m_pos = -1;
                end else begin
                    m_mem[m_pos]   = d_pix;
                    m_known[m_pos] = 1'b1;
                    if (d_eop) begin
                        if (m_pos == N - 1) begin
                            e_done  = 1'b1;
                            m_count = (m_count + 1) % 65536;
                            m_armed = continuous;
                        end else begin
                            e_err = 1'b1;
                        end
                        m_pos = -1;
                    end else begin
                        m_pos++;
                    end
                end
            end
        end
    endtask

    task automatic step();
        bit          rk;
        logic [11:0] rv;
        rk = 1'b0;
        rv = '0;
        if (rd_addr < 19'(N)) begin
            rk = m_known[int'(rd_addr)];
            rv = m_mem[int'(rd_addr)];
        end
        model_cycle();
        @(posedge clk);
        #1;
        check_eq("ready",       {31'd0, st_if.ready}, {31'd0, m_ready});
        check_eq("busy",        {31'd0, busy},        {31'd0, m_armed});
        check_eq("frame_done",  {31'd0, frame_done},  {31'd0, e_done});
        check_eq("frame_error", {31'd0, frame_error}, {31'd0, e_err});
        check_eq("frame_count", {16'd0, frame_count}, 32'(m_count));
        if (rk) check_eq("rd_data", {20'd0, rd_data}, {20'd0, rv});
    endtask

    task automatic drive(input bit v, input bit s, input bit e, input logic [11:0] p);
        d_valid             = v;
        d_sop               = s;
        d_eop               = e;
        d_pix               = p;
        st_if.valid         = v;
        st_if.startofpacket = s;
        st_if.endofpacket   = e;
        st_if.data          = enc(p);
    endtask

    task automatic cyc(input bit v, input bit s, input bit e, input logic [11:0] p);
        drive(v, s, e, p);
        rd_addr = 19'($urandom_range(0, N - 1));
        step();
    endtask

    // Idle cycles carry junk SOP/EOP to show they are ignored without valid.
    task automatic gaps(input int maxg);
        int g;
        g = (maxg > 0) ? int'($urandom_range(0, maxg)) : 0;
        repeat (g) cyc(1'b0, 1'($urandom), 1'($urandom), 12'($urandom));
    endtask

    task automatic frame(input int len, input int maxg, input int sop_again, input bit seq_pix);
        for (int i = 0; i < len; i++) begin
            gaps(maxg);
            cyc(1'b1, (i == 0) || (i == sop_again), (i == len - 1),
                seq_pix ? 12'(i) : 12'($urandom));
        end
    endtask

    task automatic do_arm();
        arm = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 12'd0);
        arm = 1'b0;
    endtask

    initial begin
        m_armed = 1'b0;
        m_pos   = -1;
        m_ready = 1'b0;
        m_count = 0;
        for (int i = 0; i < N; i++) m_known[i] = 1'b0;
        reset      = 1'b1;
        arm        = 1'b0;
        continuous = 1'b0;
        rd_addr    = '0;
        drive(1'b0, 1'b0, 1'b0, 12'd0);

        // Reset state
        repeat (3) cyc(1'b1, 1'b1, 1'b0, 12'h5A5);
        reset = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 12'd0);

        // Single armed frame with pixel i = i, then full read-back
        do_arm();
        frame(N, 0, -1, 1'b1);
        check_eq("count_first_frame", {16'd0, frame_count}, 32'd1);
        for (int k = 0; k < N; k++) begin
            drive(1'b0, 1'b0, 1'b0, 12'd0);
            rd_addr = 19'(k);
            step();
            check_eq("readback", {20'd0, rd_data}, 32'(k));
        end

        // Arm in the middle of a frame: rest discarded, next frame taken
        for (int i = 0; i < N; i++) begin
            arm = (i == 50);
            cyc(1'b1, i == 0, i == N - 1, 12'($urandom));
        end
        arm = 1'b0;
        frame(N, 0, -1, 1'b0);
        check_eq("count_mid_arm", {16'd0, frame_count}, 32'd2);

        // Early EOP at beat 99, then a good frame
        do_arm();
        frame(100, 1, -1, 1'b0);
        frame(N, 1, -1, 1'b0);
        check_eq("count_early_eop", {16'd0, frame_count}, 32'd3);

        // SOP reasserted at beat 60, frame completes 143 beats later
        do_arm();
        frame(60 + N, 0, 60, 1'b0);
        check_eq("count_resync", {16'd0, frame_count}, 32'd4);

        // Continuous capture of three frames with random gaps
        continuous = 1'b1;
        do_arm();
        repeat (3) frame(N, 3, -1, 1'b0);
        check_eq("count_continuous", {16'd0, frame_count}, 32'd7);
        continuous = 1'b0;

        // Missing EOP on the last index, then SOP+EOP on one beat, then a good frame
        for (int i = 0; i < N + 1; i++) cyc(1'b1, i == 0, 1'b0, 12'($urandom));
        cyc(1'b1, 1'b1, 1'b1, 12'($urandom));
        frame(N, 0, -1, 1'b0);
        check_eq("count_boundaries", {16'd0, frame_count}, 32'd8);

        // Reset in the middle of a capture
        do_arm();
        frame(70, 0, -1, 1'b0);
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b0, 12'($urandom));
        reset = 1'b1;
        repeat (2) cyc(1'b1, 1'b0, 1'b0, 12'($urandom));
        reset = 1'b0;
        repeat (4) cyc(1'b1, 1'b0, 1'b0, 12'($urandom));
        check_eq("count_after_reset", {16'd0, frame_count}, 32'd0);

        // Random framing, arming and occasional resets
        for (int c = 0; c < 4000; c++) begin
            arm = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 199) == 0) continuous = ~continuous;
            reset = ($urandom_range(0, 1499) == 0);
            cyc($urandom_range(0, 9) < 7, $urandom_range(0, 119) == 0,
                $urandom_range(0, 119) == 0, 12'($urandom));
        end
        arm   = 1'b0;
        reset = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 12'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
